ysyx_23060111_mem_arb: RTL and testbench

Two-requester memory arbiter and transaction sequencer for the single-cycle core. The instruction fetch unit (IF) and the load/store path (LS) share one memory port. The LS path is the load/store address, mask and data that the execute stage generates. The block grants one requester at a time, holds the memory request stable until it is accepted, waits for the response and returns it to the owner. It also checks alignment and enforces a response timeout.

---
 rtl/ysyx_23060111_mem_arb.sv | 245 ++++++++++++++++++++++++
 tb/tb_ysyx_23060111_mem_arb.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060111_mem_arb.sv
// Two-requester (IF / LS) memory arbiter with alignment check and response watchdog.
// Define YSYX_23060111_ARB_RR_EN for round-robin arbitration; fixed LS > IF priority otherwise.
module ysyx_23060111_mem_arb #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_addr,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic        ls_wen,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [2:0]  ls_size,
    output logic        ls_rsp_valid,
    output logic [31:0] ls_rsp_data,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_size,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        err,
    output logic [1:0]  err_code
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    localparam logic [16:0] TIMEOUT_L    = 17'(TIMEOUT);
    localparam logic [1:0]  CODE_ALIGN   = 2'b01;
    localparam logic [1:0]  CODE_TIMEOUT = 2'b10;

    state_t      state_r;
    logic [15:0] cnt_r;
    logic        owner_ls_r;

    logic        grant_if_s;
    logic        grant_ls_s;
    logic        hs_s;
    logic        sel_wen_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_wdata_s;
    logic [2:0]  sel_size_s;
    logic        sel_legal_s;
    logic        timeout_s;
    logic        fin_s;
    logic        fin_err_s;
    logic        fin_ls_s;
    logic [1:0]  fin_code_s;
    logic [31:0] fin_data_s;

    function automatic logic req_legal(input logic [2:0] size, input logic [1:0] lsb);
        case (size)
            3'd1:    req_legal = 1'b1;
            3'd2:    req_legal = ~lsb[0];
            3'd4:    req_legal = (lsb == 2'b00);
            default: req_legal = 1'b0;
        endcase
    endfunction

`ifdef YSYX_23060111_ARB_RR_EN
    logic last_grant_ls_r;

    // Remember who won the most recent grant so contention alternates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_ls_r <= 1'b0;
        end else if (hs_s) begin
            last_grant_ls_r <= grant_ls_s;
        end
    end
`endif

    // Grant decision: only in IDLE, never while reset is held.
    always_comb begin
        grant_if_s = 1'b0;
        grant_ls_s = 1'b0;
        if (rst || (state_r != ST_IDLE)) begin
            grant_if_s = 1'b0;
        end else if (ls_req_valid && if_req_valid) begin
`ifdef YSYX_23060111_ARB_RR_EN
            grant_ls_s = ~last_grant_ls_r;
            grant_if_s = last_grant_ls_r;
`else
            grant_ls_s = 1'b1;
`endif
        end else begin
            grant_ls_s = ls_req_valid;
            grant_if_s = if_req_valid;
        end
    end

    assign if_req_ready = grant_if_s;
    assign ls_req_ready = grant_ls_s;
    assign hs_s         = grant_if_s | grant_ls_s;
    assign timeout_s    = ({1'b0, cnt_r} + 17'd1) >= TIMEOUT_L;

    // Select the granted request; fetches are always 4-byte reads.
    always_comb begin
        if (grant_ls_s) begin
            sel_wen_s   = ls_wen;
            sel_addr_s  = ls_addr;
            sel_wdata_s = ls_wdata;
            sel_size_s  = ls_size;
        end else begin
            sel_wen_s   = 1'b0;
            sel_addr_s  = if_addr;
            sel_wdata_s = 32'd0;
            sel_size_s  = 3'd4;
        end
        sel_legal_s = req_legal(sel_size_s, sel_addr_s[1:0]);
    end

    // Work out whether a response pulse is due next cycle and what it carries.
    always_comb begin
        fin_s      = 1'b0;
        fin_err_s  = 1'b0;
        fin_ls_s   = owner_ls_r;
        fin_code_s = 2'b00;
        fin_data_s = 32'd0;
        case (state_r)
            ST_IDLE: begin
                if (hs_s && !sel_legal_s) begin
                    fin_s      = 1'b1;
                    fin_err_s  = 1'b1;
                    fin_ls_s   = grant_ls_s;
                    fin_code_s = CODE_ALIGN;
                end else begin
                    fin_s = 1'b0;
                end
            end
            ST_REQ: begin
                if (timeout_s) begin
                    fin_s      = 1'b1;
                    fin_err_s  = 1'b1;
                    fin_code_s = CODE_TIMEOUT;
                end else begin
                    fin_s = 1'b0;
                end
            end
            ST_RSP: begin
                // A response in the final allowed cycle still counts as success.
                if (mem_rsp_valid) begin
                    fin_s      = 1'b1;
                    fin_data_s = (owner_ls_r && mem_wen) ? 32'd0 : mem_rsp_data;
                end else if (timeout_s) begin
                    fin_s      = 1'b1;
                    fin_err_s  = 1'b1;
                    fin_code_s = CODE_TIMEOUT;
                end else begin
                    fin_s = 1'b0;
                end
            end
            default: begin
                fin_s = 1'b0;
            end
        endcase
    end

    // Transaction FSM, watchdog counter and the registered memory request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 16'd0;
            owner_ls_r    <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_wen       <= 1'b0;
            mem_addr      <= 32'd0;
            mem_wdata     <= 32'd0;
            mem_size      <= 3'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (hs_s) begin
                        owner_ls_r <= grant_ls_s;
                    end
                    if (hs_s && sel_legal_s) begin
                        state_r       <= ST_REQ;
                        cnt_r         <= 16'd0;
                        mem_req_valid <= 1'b1;
                        mem_wen       <= sel_wen_s;
                        mem_addr      <= sel_addr_s;
                        mem_wdata     <= sel_wdata_s;
                        mem_size      <= sel_size_s;
                    end
                end
                ST_REQ: begin
                    cnt_r <= cnt_r + 16'd1;
                    if (timeout_s) begin
                        state_r       <= ST_IDLE;
                        mem_req_valid <= 1'b0;
                    end else if (mem_req_ready) begin
                        state_r       <= ST_RSP;
                        mem_req_valid <= 1'b0;
                    end
                end
                ST_RSP: begin
                    cnt_r <= cnt_r + 16'd1;
                    if (mem_rsp_valid || timeout_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    mem_req_valid <= 1'b0;
                end
            endcase
        end
    end

    // Response pulses to the owner; err_code holds until the next error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rsp_valid <= 1'b0;
            if_rsp_data  <= 32'd0;
            ls_rsp_valid <= 1'b0;
            ls_rsp_data  <= 32'd0;
            err          <= 1'b0;
            err_code     <= 2'b00;
        end else begin
            if_rsp_valid <= fin_s & ~fin_ls_s;
            ls_rsp_valid <= fin_s & fin_ls_s;
            err          <= fin_err_s;
            if (fin_s && fin_ls_s) begin
                ls_rsp_data <= fin_data_s;
            end
            if (fin_s && !fin_ls_s) begin
                if_rsp_data <= fin_data_s;
            end
            if (fin_err_s) begin
                err_code <= fin_code_s;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060111_mem_arb.sv
// Self-checking bench for ysyx_23060111_mem_arb: vector table, directed corner sequences
// and randomized single transactions checked against a behavioural model.
module tb_ysyx_23060111_mem_arb;
    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_rsp_valid;
    logic [31:0] if_addr, if_rsp_data;
    logic        ls_req_valid, ls_req_ready, ls_wen, ls_rsp_valid;
    logic [31:0] ls_addr, ls_wdata, ls_rsp_data;
    logic [2:0]  ls_size;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rsp_data;
    logic [2:0]  mem_size;
    logic        err;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    ysyx_23060111_mem_arb #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_wen(ls_wen),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_size(ls_size),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .err(err), .err_code(err_code)
    );

    typedef struct {
        logic        ls;
        logic        wen;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    vec_t        tbl [12];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [1:0]  exp_code = 2'b00;
    bit          mdl_last_ls = 1'b0;
    bit          g_ls;
    logic        r_lv, r_iv, r_wen, r_els, r_eerr;
    logic [1:0]  r_sel;
    logic [2:0]  r_size;
    logic [31:0] r_la, r_ia, r_wd, r_rd, r_ed;
    int          r_st, r_dl, r_pick;

    task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference rules: which requester wins and whether its request is legal.
    function automatic bit mdl_pick(input bit lv, input bit iv);
        if (lv && iv) begin
`ifdef YSYX_23060111_ARB_RR_EN
            return !mdl_last_ls;
`else
            return 1'b1;
`endif
        end
        return lv;
    endfunction

    function automatic bit mdl_legal(input bit is_ls, input int unsigned addr, input int unsigned size);
        if (!is_ls) return (addr % 4) == 0;
        if (size == 1) return 1'b1;
        if (size == 2) return (addr % 2) == 0;
        if (size == 4) return (addr % 4) == 0;
        return 1'b0;
    endfunction

    task automatic chk_rsp(input logic e_ls, input logic e_err, input logic [31:0] e_data);
        chk_b("ls_rsp_valid", ls_rsp_valid, e_ls);
        chk_b("if_rsp_valid", if_rsp_valid, !e_ls);
        chk_w("rsp_data", e_ls ? ls_rsp_data : if_rsp_data, e_data);
        chk_b("err", err, e_err);
        chk_w("err_code", {30'd0, err_code}, {30'd0, exp_code});
    endtask

    task automatic do_txn(input logic lv, input logic iv, input logic wen,
                          input logic [31:0] la, input logic [2:0] lsz, input logic [31:0] wd,
                          input logic [31:0] ia, input int stall, input int dly,
                          input logic [31:0] rd, input logic e_ls, input logic e_err,
                          input logic [31:0] e_data);
        logic [31:0] e_addr, e_wdata;
        logic [2:0]  e_size;
        logic        e_wen;
        e_addr  = e_ls ? la : ia;
        e_size  = e_ls ? lsz : 3'd4;
        e_wen   = e_ls & wen;
        e_wdata = e_ls ? wd : 32'd0;
        ls_req_valid = lv; ls_wen = wen; ls_addr = la; ls_size = lsz; ls_wdata = wd;
        if_req_valid = iv; if_addr = ia;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        #1;
        chk_b("ls_req_ready", ls_req_ready, e_ls);
        chk_b("if_req_ready", if_req_ready, !e_ls);
        tick();
        ls_req_valid = 1'b0; if_req_valid = 1'b0;
        mdl_last_ls = e_ls;
        if (e_err) begin
            exp_code = 2'b01;
            chk_rsp(e_ls, 1'b1, 32'd0);
            chk_b("illegal_no_mem_req", mem_req_valid, 1'b0);
        end else begin
            chk_b("pulse_single", ls_rsp_valid | if_rsp_valid | err, 1'b0);
            chk_b("mem_req_valid", mem_req_valid, 1'b1);
            chk_w("mem_addr", mem_addr, e_addr);
            chk_w("mem_size", {29'd0, mem_size}, {29'd0, e_size});
            chk_b("mem_wen", mem_wen, e_wen);
            chk_w("mem_wdata", mem_wdata, e_wdata);
            for (int s = 0; s < stall; s++) begin
                mem_rsp_valid = 1'($urandom_range(0, 1));
                mem_rsp_data  = $urandom;
                tick();
                chk_b("stall_valid", mem_req_valid, 1'b1);
                chk_w("stall_addr", mem_addr, e_addr);
                chk_w("stall_wdata", mem_wdata, e_wdata);
                chk_w("stall_size", {29'd0, mem_size}, {29'd0, e_size});
                chk_b("stall_wen", mem_wen, e_wen);
                chk_b("stall_no_rsp", ls_rsp_valid | if_rsp_valid, 1'b0);
            end
            mem_rsp_valid = 1'b0; mem_req_ready = 1'b1;
            tick();
            mem_req_ready = 1'b0;
            chk_b("req_dropped", mem_req_valid, 1'b0);
            for (int d = 0; d < dly; d++) begin
                tick();
                chk_b("wait_no_rsp", ls_rsp_valid | if_rsp_valid | err, 1'b0);
            end
            mem_rsp_valid = 1'b1; mem_rsp_data = rd;
            tick();
            mem_rsp_valid = 1'b0;
            chk_rsp(e_ls, 1'b0, e_data);
        end
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 32'h8000_0000, 3'd4, 32'd0,         32'h0000_0413, 1'b0, 32'h0000_0413};
        tbl[1]  = '{1'b0, 1'b0, 32'h8000_0002, 3'd4, 32'd0,         32'h1111_1111, 1'b1, 32'd0};
        tbl[2]  = '{1'b1, 1'b0, 32'h8000_0002, 3'd4, 32'd0,         32'h2222_2222, 1'b1, 32'd0};
        tbl[3]  = '{1'b1, 1'b0, 32'h8000_0003, 3'd1, 32'd0,         32'h1234_5678, 1'b0, 32'h1234_5678};
        tbl[4]  = '{1'b1, 1'b0, 32'h8000_0001, 3'd2, 32'd0,         32'h3333_3333, 1'b1, 32'd0};
        tbl[5]  = '{1'b1, 1'b0, 32'h8000_0006, 3'd2, 32'd0,         32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D};
        tbl[6]  = '{1'b1, 1'b1, 32'h8000_0010, 3'd4, 32'h1122_3344, 32'h5555_5555, 1'b0, 32'd0};
        tbl[7]  = '{1'b1, 1'b0, 32'h8000_0020, 3'd3, 32'd0,         32'h6666_6666, 1'b1, 32'd0};
        tbl[8]  = '{1'b1, 1'b0, 32'h8000_0020, 3'd0, 32'd0,         32'h7777_7777, 1'b1, 32'd0};
        tbl[9]  = '{1'b1, 1'b1, 32'h8000_0020, 3'd7, 32'hAAAA_AAAA, 32'h8888_8888, 1'b1, 32'd0};
        tbl[10] = '{1'b1, 1'b0, 32'h8000_0004, 3'd4, 32'd0,         32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D};
        tbl[11] = '{1'b0, 1'b0, 32'h8000_0001, 3'd4, 32'd0,         32'h9999_9999, 1'b1, 32'd0};

        // Reset with both requesters asking: readies forced low, everything zero.
        rst = 1'b1;
        if_req_valid = 1'b1; if_addr = 32'h8000_0000;
        ls_req_valid = 1'b1; ls_wen = 1'b0; ls_addr = 32'h8000_0000; ls_wdata = 32'd0; ls_size = 3'd4;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'd0;
        tick();
        tick();
        chk_b("rst_if_ready", if_req_ready, 1'b0);
        chk_b("rst_ls_ready", ls_req_ready, 1'b0);
        chk_b("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk_w("rst_mem_addr", mem_addr, 32'd0);
        chk_b("rst_rsp_valids", if_rsp_valid | ls_rsp_valid | err, 1'b0);
        chk_w("rst_err_code", {30'd0, err_code}, 32'd0);
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        rst = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) begin
            do_txn(tbl[i].ls, !tbl[i].ls, tbl[i].wen, tbl[i].addr, tbl[i].size, tbl[i].wdata,
                   tbl[i].addr, 0, 0, tbl[i].rdata, tbl[i].ls, tbl[i].exp_err, tbl[i].exp_data);
        end

        // Store held off by memory for three cycles.
        do_txn(1'b1, 1'b0, 1'b1, 32'h8000_1000, 3'd4, 32'hDEAD_BEEF, 32'h8000_0000,
               3, 0, 32'h5A5A_5A5A, 1'b1, 1'b0, 32'd0);

        // Memory accepts but never answers: abort after TMO cycles in REQ+RSP.
        ls_req_valid = 1'b1; ls_wen = 1'b0; ls_addr = 32'h8000_0100; ls_size = 3'd4;
        #1;
        chk_b("tmo_ls_ready", ls_req_ready, 1'b1);
        tick();
        ls_req_valid = 1'b0;
        mdl_last_ls = 1'b1;
        chk_b("tmo_mem_req_valid", mem_req_valid, 1'b1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int c = 2; c <= 8; c++) begin
            chk_b("tmo_no_early_rsp", ls_rsp_valid | if_rsp_valid | err, 1'b0);
            tick();
        end
        exp_code = 2'b10;
        chk_rsp(1'b1, 1'b1, 32'd0);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hFFFF_FFFF;
        tick();
        mem_rsp_valid = 1'b0;
        chk_b("late_rsp_ignored", ls_rsp_valid | if_rsp_valid | err, 1'b0);
        chk_w("late_err_code_held", {30'd0, err_code}, 32'd2);
        do_txn(1'b0, 1'b1, 1'b0, 32'd0, 3'd4, 32'd0, 32'h8000_0040, 0, 0,
               32'h0010_0073, 1'b0, 1'b0, 32'h0010_0073);

        // Reset while waiting for a response.
        ls_req_valid = 1'b1; ls_wen = 1'b0; ls_addr = 32'h8000_0200; ls_size = 3'd4;
        tick();
        ls_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        if_req_valid = 1'b1; ls_req_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk_b("mid_rst_if_ready", if_req_ready, 1'b0);
        chk_b("mid_rst_ls_ready", ls_req_ready, 1'b0);
        chk_b("mid_rst_mem_req_valid", mem_req_valid, 1'b0);
        chk_w("mid_rst_mem_addr", mem_addr, 32'd0);
        chk_w("mid_rst_mem_size", {29'd0, mem_size}, 32'd0);
        chk_w("mid_rst_if_rsp_data", if_rsp_data, 32'd0);
        chk_w("mid_rst_err_code", {30'd0, err_code}, 32'd0);
        tick();
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0F0F_0F0F;
        rst = 1'b0;
        mdl_last_ls = 1'b0;
        exp_code = 2'b00;
        tick();
        chk_b("post_rst_no_rsp", ls_rsp_valid | if_rsp_valid | err, 1'b0);
        mem_rsp_valid = 1'b0;
        do_txn(1'b0, 1'b1, 1'b0, 32'd0, 3'd4, 32'd0, 32'h8000_0080, 0, 0,
               32'h0000_0013, 1'b0, 1'b0, 32'h0000_0013);

        // Both requesters held valid for four back-to-back transactions.
        ls_req_valid = 1'b1; ls_wen = 1'b0; ls_addr = 32'h8000_0300; ls_size = 3'd4; ls_wdata = 32'd0;
        if_req_valid = 1'b1; if_addr = 32'h8000_0400;
        for (int i = 0; i < 4; i++) begin
`ifdef YSYX_23060111_ARB_RR_EN
            g_ls = (i % 2) == 0;
`else
            g_ls = 1'b1;
`endif
            #1;
            chk_b("cont_ls_ready", ls_req_ready, g_ls);
            chk_b("cont_if_ready", if_req_ready, !g_ls);
            tick();
            chk_w("cont_mem_addr", mem_addr, g_ls ? 32'h8000_0300 : 32'h8000_0400);
            chk_b("cont_busy_no_ready", ls_req_ready | if_req_ready, 1'b0);
            mem_req_ready = 1'b1;
            tick();
            mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1000 + i;
            tick();
            mem_rsp_valid = 1'b0;
            mdl_last_ls = g_ls;
            chk_rsp(g_ls, 1'b0, 32'h1000 + i);
        end
        ls_req_valid = 1'b0; if_req_valid = 1'b0;
        tick();

        // Randomized single transactions against the model.
        for (int k = 0; k < 200; k++) begin
            r_sel  = 2'($urandom_range(1, 3));
            r_lv   = r_sel[0];
            r_iv   = r_sel[1];
            r_wen  = 1'($urandom_range(0, 1));
            r_la   = 32'h8000_0000 + $urandom_range(0, 255);
            r_ia   = 32'h8000_0000 + ($urandom_range(0, 63) << 2);
            if ($urandom_range(0, 3) == 0) r_ia = r_ia + $urandom_range(1, 3);
            r_pick = $urandom_range(0, 9);
            r_size = (r_pick < 3) ? 3'd1 : (r_pick < 6) ? 3'd2 : (r_pick < 9) ? 3'd4
                                         : 3'($urandom_range(0, 7));
            r_wd   = $urandom;
            r_rd   = $urandom;
            r_st   = $urandom_range(0, 2);
            r_dl   = $urandom_range(0, 2);
            r_els  = mdl_pick(r_lv, r_iv);
            r_eerr = !mdl_legal(r_els, r_els ? r_la : r_ia, r_size);
            r_ed   = (r_eerr || (r_els && r_wen)) ? 32'd0 : r_rd;
            do_txn(r_lv, r_iv, r_wen, r_la, r_size, r_wd, r_ia, r_st, r_dl,
                   r_rd, r_els, r_eerr, r_ed);
        end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
